pwm_pulse_gen: RTL and testbench

Parametrised multi-channel periodic pulse generator. It produces NCH independent output waveforms (a[i]), each with a programmable period and high time, in either continuous or one-shot mode. It replaces fixed-ratio clock/strobe generation in benches and RTL: a low phase followed by a high phase, with run-time reconfiguration that does not glitch.

---
 rtl/pwm_pulse_gen.sv | 177 +++++++++++++++++
 tb/tb_pwm_pulse_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_pulse_gen.sv
// pwm_pulse_gen - multi-channel periodic pulse generator.
//
// Each channel produces a waveform with a programmable period P and high
// time H. Within every period the output is low first, then high for the
// final H cycles. A channel runs continuously or fires once (one-shot).
// Config writes to a running channel are held as pending and applied at
// the next period boundary, so the waveform never glitches mid-period.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   cfg_valid   config write strobe, accepted every cycle it is high
//   cfg_ch      target channel (values >= NCH are ignored)
//   cfg_period  period P in cycles (P=0 disables the channel)
//   cfg_high    high time H in cycles
//   cfg_oneshot 1 = one-shot, 0 = continuous
//   start       per-channel start request
//   stop        per-channel stop request (wins over start)
//   a           registered pulse outputs
//   busy        channel is running
//   done        one-cycle pulse when a one-shot period completes
module pwm_pulse_gen #(
  parameter int CW = 8,
  parameter int NCH = 2,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic [CW-1:0]  cfg_high,
  input  logic           cfg_oneshot,
  input  logic [NCH-1:0] start,
  input  logic [NCH-1:0] stop,
  output logic [NCH-1:0] a,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] done
);

  typedef enum logic {IDLE, RUN} state_t;

  // Output level for counter value k. P-H is only formed when H<P, so it
  // cannot underflow.
  function automatic logic level_at(input logic [CW-1:0] k,
                                    input logic [CW-1:0] p,
                                    input logic [CW-1:0] h);
    if (h == '0)
      return 1'b0;
    else if (h >= p)
      return 1'b1;
    else
      return (k >= (p - h));
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      state_t        state_reg, state_next;
      logic [CW-1:0] cnt_reg, cnt_next;
      logic [CW-1:0] act_p_reg, act_p_next, act_h_reg, act_h_next;
      logic [CW-1:0] pend_p_reg, pend_p_next, pend_h_reg, pend_h_next;
      logic          act_os_reg, act_os_next, pend_os_reg, pend_os_next;
      logic          pend_flag_reg, pend_flag_next;
      logic          a_reg, a_next, done_reg, done_next;

      logic          wr;
      logic          have_upd;
      logic [CW-1:0] upd_p, upd_h, start_p;
      logic          upd_os;

      // Channel indices that do not exist never match, so out-of-range
      // writes fall on the floor.
      assign wr = cfg_valid && (cfg_ch == CHW'(gi));

      // A write landing in the same cycle as a boundary or stop is the
      // newest config and takes precedence over the stored pending one.
      assign have_upd = wr || pend_flag_reg;
      assign upd_p    = wr ? cfg_period  : pend_p_reg;
      assign upd_h    = wr ? cfg_high    : pend_h_reg;
      assign upd_os   = wr ? cfg_oneshot : pend_os_reg;
      assign start_p  = wr ? cfg_period  : act_p_reg;

      always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        act_p_next     = act_p_reg;
        act_h_next     = act_h_reg;
        act_os_next    = act_os_reg;
        pend_p_next    = pend_p_reg;
        pend_h_next    = pend_h_reg;
        pend_os_next   = pend_os_reg;
        pend_flag_next = pend_flag_reg;
        done_next      = 1'b0;

        case (state_reg)
          IDLE: begin
            if (wr) begin
              act_p_next  = cfg_period;
              act_h_next  = cfg_high;
              act_os_next = cfg_oneshot;
            end
            if (start[gi] && !stop[gi] && (start_p != '0)) begin
              state_next = RUN;
              cnt_next   = '0;
            end
          end
          RUN: begin
            if (wr) begin
              pend_p_next    = cfg_period;
              pend_h_next    = cfg_high;
              pend_os_next   = cfg_oneshot;
              pend_flag_next = 1'b1;
            end
            if (stop[gi] || (cnt_reg == act_p_reg - CW'(1))) begin
              cnt_next = '0;
              if (have_upd) begin
                act_p_next     = upd_p;
                act_h_next     = upd_h;
                act_os_next    = upd_os;
                pend_flag_next = 1'b0;
              end
              if (stop[gi]) begin
                state_next = IDLE;
              end else if (act_os_reg) begin
                state_next = IDLE;
                done_next  = 1'b1;
              end else if (have_upd && (upd_p == '0)) begin
                state_next = IDLE;
              end
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end
          default: state_next = IDLE;
        endcase

        // The output is computed from next-cycle counter and config so the
        // registered level lines up with the counter value it belongs to.
        a_next = (state_next == RUN) && level_at(cnt_next, act_p_next, act_h_next);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg     <= IDLE;
          cnt_reg       <= '0;
          act_p_reg     <= '0;
          act_h_reg     <= '0;
          act_os_reg    <= 1'b0;
          pend_p_reg    <= '0;
          pend_h_reg    <= '0;
          pend_os_reg   <= 1'b0;
          pend_flag_reg <= 1'b0;
          a_reg         <= 1'b0;
          done_reg      <= 1'b0;
        end else begin
          state_reg     <= state_next;
          cnt_reg       <= cnt_next;
          act_p_reg     <= act_p_next;
          act_h_reg     <= act_h_next;
          act_os_reg    <= act_os_next;
          pend_p_reg    <= pend_p_next;
          pend_h_reg    <= pend_h_next;
          pend_os_reg   <= pend_os_next;
          pend_flag_reg <= pend_flag_next;
          a_reg         <= a_next;
          done_reg      <= done_next;
        end
      end

      assign a[gi]    = a_reg;
      assign busy[gi] = (state_reg == RUN);
      assign done[gi] = done_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pwm_pulse_gen.sv
module tb_pwm_pulse_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // dut0: default build CW=8, NCH=2
  logic       cv0, cch0, cos0;
  logic [7:0] cp0, chh0;
  logic [1:0] st0, sp0, a0, b0, d0;
  // dut1: CW=4, NCH=4
  logic       cv1, cos1;
  logic [1:0] cch1;
  logic [3:0] cp1, chh1, st1, sp1, a1, b1, d1;
  // dut2: CW=4, NCH=3 (has an unused channel code)
  logic       cv2, cos2;
  logic [1:0] cch2;
  logic [3:0] cp2, chh2;
  logic [2:0] st2, sp2, a2, b2, d2;

  int checks = 0;
  int failures = 0;

  pwm_pulse_gen #(.CW(8), .NCH(2)) dut0 (
    .clk(clk), .rst(rst), .cfg_valid(cv0), .cfg_ch(cch0), .cfg_period(cp0),
    .cfg_high(chh0), .cfg_oneshot(cos0), .start(st0), .stop(sp0),
    .a(a0), .busy(b0), .done(d0));

  pwm_pulse_gen #(.CW(4), .NCH(4)) dut1 (
    .clk(clk), .rst(rst), .cfg_valid(cv1), .cfg_ch(cch1), .cfg_period(cp1),
    .cfg_high(chh1), .cfg_oneshot(cos1), .start(st1), .stop(sp1),
    .a(a1), .busy(b1), .done(d1));

  pwm_pulse_gen #(.CW(4), .NCH(3)) dut2 (
    .clk(clk), .rst(rst), .cfg_valid(cv2), .cfg_ch(cch2), .cfg_period(cp2),
    .cfg_high(chh2), .cfg_oneshot(cos2), .start(st2), .stop(sp2),
    .a(a2), .busy(b2), .done(d2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg0(input logic ch, input logic [7:0] p, input logic [7:0] h,
                      input logic os, input logic [1:0] st);
    cv0 = 1'b1; cch0 = ch; cp0 = p; chh0 = h; cos0 = os; st0 = st;
    tick();
    cv0 = 1'b0; cos0 = 1'b0; st0 = '0;
  endtask

  // ch1 one-shot P=10 H=3: 7 low, 3 high, then done for one cycle.
  task automatic oneshot_ch1(input string tag);
    for (int k = 0; k < 10; k++) begin
      chk({tag, "_a"}, a0[1], (k >= 7));
      chk({tag, "_busy"}, b0[1], 1);
      chk({tag, "_done"}, d0[1], 0);
      chk({tag, "_ch0"}, a0[0], 0);
      tick();
    end
    chk({tag, "_end_a"}, a0[1], 0);
    chk({tag, "_end_busy"}, b0[1], 0);
    chk({tag, "_end_done"}, d0[1], 1);
    tick();
    chk({tag, "_done_clr"}, d0[1], 0);
    $display("txn %s one-shot complete", tag);
  endtask

  initial begin
    rst = 1'b1;
    cv0 = 0; cch0 = 0; cp0 = 0; chh0 = 0; cos0 = 0; st0 = 0; sp0 = 0;
    cv1 = 0; cch1 = 0; cp1 = 0; chh1 = 0; cos1 = 0; st1 = 0; sp1 = 0;
    cv2 = 0; cch2 = 0; cp2 = 0; chh2 = 0; cos2 = 0; st2 = 0; sp2 = 0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_a", a0, 0);
    chk("rst_busy", b0, 0);
    chk("rst_done", d0, 0);
    chk("rst_a1", a1, 0);
    chk("rst_busy1", b1, 0);
    $display("txn reset");

    // Continuous P=100 H=20 on ch0: 80 low, 20 high, three periods.
    cfg0(1'b0, 8'd100, 8'd20, 1'b0, 2'b01);
    chk("t1_busy", b0[0], 1);
    for (int k = 0; k < 300; k++) begin
      chk("t1_a", a0[0], ((k % 100) >= 80));
      tick();
    end
    $display("txn t1 three periods P=100 H=20");

    // Reconfigure at cnt=40: current period finishes as 80/20, then 5/5.
    for (int k = 0; k < 40; k++) begin
      chk("t3_pre", a0[0], 0);
      tick();
    end
    cfg0(1'b0, 8'd10, 8'd5, 1'b0, 2'b00);
    for (int k = 41; k < 100; k++) begin
      chk("t3_old", a0[0], (k >= 80));
      chk("t3_busy", b0[0], 1);
      tick();
    end
    for (int k = 0; k < 30; k++) begin
      chk("t3_new", a0[0], ((k % 10) >= 5));
      chk("t3_new_busy", b0[0], 1);
      if (k == 13) st0 = 2'b01;   // start while running: ignored
      tick();
      st0 = 2'b00;
    end
    $display("txn t3 reconfig mid-period");

    // stop and start together: stop wins, no done.
    sp0 = 2'b01; st0 = 2'b01;
    tick();
    sp0 = 2'b00; st0 = 2'b00;
    chk("t5_stop_busy", b0[0], 0);
    chk("t5_stop_a", a0[0], 0);
    chk("t5_stop_done", d0[0], 0);
    tick();
    chk("t5_stop_done2", d0[0], 0);
    chk("t5_stop_busy2", b0[0], 0);
    $display("txn t5 stop+start");

    // Edge values.
    cfg0(1'b0, 8'd8, 8'd0, 1'b0, 2'b01);
    for (int k = 0; k < 16; k++) begin
      chk("t4_h0_a", a0[0], 0);
      chk("t4_h0_busy", b0[0], 1);
      tick();
    end
    sp0 = 2'b01; tick(); sp0 = 2'b00;
    chk("t4_h0_stop", b0[0], 0);
    cfg0(1'b0, 8'd8, 8'd8, 1'b0, 2'b01);
    for (int k = 0; k < 16; k++) begin
      chk("t4_hp_a", a0[0], 1);
      chk("t4_hp_busy", b0[0], 1);
      tick();
    end
    sp0 = 2'b01; tick(); sp0 = 2'b00;
    chk("t4_hp_stop_a", a0[0], 0);
    chk("t4_hp_stop_busy", b0[0], 0);
    cfg0(1'b0, 8'd0, 8'd3, 1'b0, 2'b01);
    chk("t4_p0_busy", b0[0], 0);
    tick();
    chk("t4_p0_busy2", b0[0], 0);
    chk("t4_p0_a", a0[0], 0);
    $display("txn t4 edge values");

    // One-shot on ch1, twice.
    cfg0(1'b1, 8'd10, 8'd3, 1'b1, 2'b10);
    oneshot_ch1("t2_first");
    st0 = 2'b10; tick(); st0 = 2'b00;
    oneshot_ch1("t2_again");

    // Reset in the middle of a one-shot.
    cfg0(1'b1, 8'd10, 8'd3, 1'b1, 2'b10);
    for (int k = 0; k < 8; k++) tick();
    chk("t5_mid_a", a0[1], 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_a", a0, 0);
    chk("t5_rst_busy", b0, 0);
    chk("t5_rst_done", d0, 0);
    tick();
    chk("t5_rst_done2", d0, 0);
    st0 = 2'b10; tick(); st0 = 2'b00;
    chk("t5_rst_cfg_cleared", b0[1], 0);
    $display("txn t5 reset mid one-shot");

    // Four independent channels started together on the CW=4 build.
    cv1 = 1'b1;
    cch1 = 2'd0; cp1 = 4'd15; chh1 = 4'd4; cos1 = 1'b0; tick();
    cch1 = 2'd1; cp1 = 4'd6;  chh1 = 4'd2; tick();
    cch1 = 2'd2; cp1 = 4'd5;  chh1 = 4'd5; tick();
    cch1 = 2'd3; cp1 = 4'd3;  chh1 = 4'd1; cos1 = 1'b1; tick();
    cv1 = 1'b0; cos1 = 1'b0;
    chk("t6_idle_busy", b1, 0);
    st1 = 4'hF; tick(); st1 = 4'h0;
    for (int k = 0; k < 45; k++) begin
      logic [3:0] ea, eb, ed;
      ea = {(k == 2), 1'b1, ((k % 6) >= 4), ((k % 15) >= 11)};
      eb = {(k < 3), 3'b111};
      ed = {(k == 3), 3'b000};
      chk("t6_a", a1, ea);
      chk("t6_busy", b1, eb);
      chk("t6_done", d1, ed);
      tick();
    end
    $display("txn t6 four channels");

    // Unused channel code on the NCH=3 build is ignored.
    cv2 = 1'b1; cch2 = 2'd3; cp2 = 4'd5; chh2 = 4'd2; tick(); cv2 = 1'b0;
    st2 = 3'b111; tick(); st2 = 3'b000;
    chk("t6_badch_busy", b2, 0);
    chk("t6_badch_a", a2, 0);
    cv2 = 1'b1; cch2 = 2'd2; st2 = 3'b100; tick(); cv2 = 1'b0; st2 = 3'b000;
    for (int k = 0; k < 10; k++) begin
      chk("t6_ch2_busy", b2, 3'b100);
      chk("t6_ch2_a", a2[2], ((k % 5) >= 3));
      tick();
    end
    $display("txn t6 ignored channel code");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
